gcd_job_sequencer: RTL and testbench



---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_wait_timer.sv | 40 ++++
 rtl/gcd_job_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD job sequencer and its watchdog.
package gcd_pkg;

  localparam int GCD_WIDTH          = 16;
  localparam int GCD_TIMEOUT_CYCLES = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT    = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_wait_timer.sv
// Watchdog for the WAIT phase: counts enabled cycles after a clear and raises a
// sticky expired flag one cycle after the count reaches TIMEOUT_CYCLES-1.
module gcd_wait_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_r;
  logic             expired_r;

  // Cycle counter and sticky expiry flag; the counter parks at TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= '0;
      expired_r <= 1'b0;
    end else if (clear) begin
      count_r   <= '0;
      expired_r <= 1'b0;
    end else if (enable) begin
      if (count_r != CNT_MAX) begin
        count_r <= count_r + CNT_W'(1);
      end
      expired_r <= expired_r | (count_r == CNT_LAST);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front-end that feeds operand pairs to the GCD core and returns its result.
// Define GCD_STATS_EN to add the stat_jobs / stat_max_wait counters.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data_in,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err
`ifdef GCD_STATS_EN
  ,
  output logic [15:0]      stat_jobs,
  output logic [15:0]      stat_max_wait
`endif
);

  gcd_state_e       state_r, state_nxt_s;
  logic             in_ready_r, in_ready_nxt_s;
  logic             start_r, start_nxt_s;
  logic [WIDTH-1:0] data_r, data_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [WIDTH-1:0] out_gcd_r, out_gcd_nxt_s;
  logic             out_err_r, out_err_nxt_s;
  logic             timer_clr_s, timer_en_s, expired_s, enter_out_s;

  gcd_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nxt_s     = state_r;
    start_nxt_s     = start_r;
    data_nxt_s      = data_r;
    b_nxt_s         = b_r;
    out_valid_nxt_s = out_valid_r;
    out_gcd_nxt_s   = out_gcd_r;
    out_err_nxt_s   = out_err_r;
    timer_clr_s     = 1'b0;
    timer_en_s      = 1'b0;
    enter_out_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          b_nxt_s = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // A zero operand makes the answer the other operand; skip the core.
            state_nxt_s     = ST_OUT;
            out_valid_nxt_s = 1'b1;
            out_gcd_nxt_s   = in_a | in_b;
            out_err_nxt_s   = 1'b0;
            enter_out_s     = 1'b1;
          end else begin
            state_nxt_s = ST_LOAD_A;
            start_nxt_s = 1'b1;
            data_nxt_s  = in_a;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        state_nxt_s = ST_LOAD_B;
        data_nxt_s  = b_r;
      end
      ST_LOAD_B: begin
        state_nxt_s = ST_WAIT;
        timer_clr_s = 1'b1;
      end
      ST_WAIT: begin
        timer_en_s = 1'b1;
        if (gcd_done) begin
          state_nxt_s     = ST_OUT;
          start_nxt_s     = 1'b0;
          out_valid_nxt_s = 1'b1;
          out_gcd_nxt_s   = gcd_result;
          out_err_nxt_s   = 1'b0;
          enter_out_s     = 1'b1;
        end else if (expired_s) begin
          state_nxt_s     = ST_OUT;
          start_nxt_s     = 1'b0;
          out_valid_nxt_s = 1'b1;
          out_gcd_nxt_s   = '0;
          out_err_nxt_s   = 1'b1;
          enter_out_s     = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s     = ST_IDLE;
          out_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        start_nxt_s     = 1'b0;
        out_valid_nxt_s = 1'b0;
      end
    endcase
    in_ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      start_r     <= 1'b0;
      data_r      <= '0;
      b_r         <= '0;
      out_valid_r <= 1'b0;
      out_gcd_r   <= '0;
      out_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      start_r     <= start_nxt_s;
      data_r      <= data_nxt_s;
      b_r         <= b_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_gcd_r   <= out_gcd_nxt_s;
      out_err_r   <= out_err_nxt_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign gcd_start   = start_r;
  assign gcd_data_in = data_r;
  assign out_valid   = out_valid_r;
  assign out_gcd     = out_gcd_r;
  assign out_err     = out_err_r;

`ifdef GCD_STATS_EN
  logic [15:0] stat_jobs_r, stat_max_wait_r, wait_len_r, wait_sat_s;
  logic [16:0] wait_total_s;

  // wait_len_r counts completed WAIT cycles, so the exit cycle adds one more.
  assign wait_total_s = {1'b0, wait_len_r} + 17'd1;
  assign wait_sat_s   = wait_total_s[16] ? 16'hFFFF : wait_total_s[15:0];

  // Job counter and longest-WAIT tracker, updated as a result enters OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_len_r      <= 16'd0;
      stat_jobs_r     <= 16'd0;
      stat_max_wait_r <= 16'd0;
    end else begin
      if (state_r == ST_LOAD_B) begin
        wait_len_r <= 16'd0;
      end else if ((state_r == ST_WAIT) && (wait_len_r != 16'hFFFF)) begin
        wait_len_r <= wait_len_r + 16'd1;
      end
      if (enter_out_s) begin
        stat_jobs_r <= stat_jobs_r + 16'd1;
      end
      if (enter_out_s && (state_r == ST_WAIT) && (wait_sat_s > stat_max_wait_r)) begin
        stat_max_wait_r <= wait_sat_s;
      end
    end
  end

  assign stat_jobs     = stat_jobs_r;
  assign stat_max_wait = stat_max_wait_r;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomised self-checking bench for gcd_job_sequencer with a behavioural GCD core.
module tb_gcd_job_sequencer;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         gcd_start;
  logic [W-1:0] gcd_data_in;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         out_valid, out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
`ifdef GCD_STATS_EN
  logic [15:0]  stat_jobs, stat_max_wait;
  logic [15:0]  exp_jobs = 16'd0;
  int           exp_max = 0;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural core state
  int           core_phase = 0;
  int           core_cnt   = 0;
  int           core_delay = 0;
  bit           core_hang  = 1'b0;
  logic [W-1:0] core_a, core_b;

  gcd_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .gcd_start   (gcd_start),
    .gcd_data_in (gcd_data_in),
    .gcd_done    (gcd_done),
    .gcd_result  (gcd_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err)
`ifdef GCD_STATS_EN
    ,
    .stat_jobs     (stat_jobs),
    .stat_max_wait (stat_max_wait)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Core model: latch A then B off the bus, answer after core_delay cycles.
  always @(negedge clk) begin
    if (!gcd_start) begin
      core_phase = 0;
      gcd_done   = 1'b0;
      gcd_result = W'($urandom);
    end else begin
      case (core_phase)
        0: begin core_a = gcd_data_in; core_phase = 1; end
        1: begin core_b = gcd_data_in; core_cnt = core_delay; core_phase = 2; end
        default: begin
          if (!core_hang) begin
            if (core_cnt == 0) begin
              gcd_done   = 1'b1;
              gcd_result = ref_gcd(core_a, core_b);
            end else begin
              core_cnt--;
              gcd_result = W'($urandom);
            end
          end
        end
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  in_ready, 1);
    check_eq({tag, "_start"},     gcd_start, 0);
    check_eq({tag, "_data"},      gcd_data_in, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_gcd"},   out_gcd, 0);
    check_eq({tag, "_out_err"},   out_err, 0);
`ifdef GCD_STATS_EN
    check_eq({tag, "_stat_jobs"}, stat_jobs, 0);
    check_eq({tag, "_stat_max"},  stat_max_wait, 0);
`endif
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hang, input int dly, input int hold);
    logic [W-1:0] eg;
    logic         ee;
    bit           bypass;
    int           w_entry, k;
    bypass = (a == 0) || (b == 0);
    if (bypass) begin
      eg = a | b; ee = 1'b0;
    end else if (hang) begin
      eg = '0;    ee = 1'b1;
    end else begin
      eg = ref_gcd(a, b); ee = 1'b0;
    end
    core_hang  = hang;
    core_delay = dly;
    check_eq("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
    check_eq("busy_in_ready", in_ready, 0);
    if (bypass) begin
      check_eq("bypass_valid", out_valid, 1);
      check_eq("bypass_start", gcd_start, 0);
    end else begin
      check_eq("load_a_start", gcd_start, 1);
      check_eq("load_a_data", gcd_data_in, a);
      @(negedge clk);
      check_eq("load_b_start", gcd_start, 1);
      check_eq("load_b_data", gcd_data_in, b);
      @(negedge clk);
      w_entry = cyc;
      k = 0;
      while (!out_valid && k < 40) begin
        check_eq("wait_start", gcd_start, 1);
        @(negedge clk);
        k++;
      end
      check_eq("wait_len", cyc - w_entry, hang ? (TMO + 1) : (dly + 1));
      check_eq("out_start", gcd_start, 0);
`ifdef GCD_STATS_EN
      if (cyc - w_entry > exp_max) exp_max = cyc - w_entry;
`endif
    end
    check_eq("out_gcd", out_gcd, eg);
    check_eq("out_err", out_err, ee);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_gcd", out_gcd, eg);
      check_eq("hold_err", out_err, ee);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_hs_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 1);
`ifdef GCD_STATS_EN
    exp_jobs = exp_jobs + 16'd1;
    check_eq("stat_jobs", stat_jobs, exp_jobs);
    check_eq("stat_max_wait", stat_max_wait, exp_max);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_job(16'd143, 16'd78, 1'b0, 3, 0);
    run_job(16'd0,   16'd45, 1'b0, 0, 0);
    run_job(16'd0,   16'd0,  1'b0, 0, 0);
    run_job(16'd200, 16'd300, 1'b1, 0, 0);
    run_job(16'd48,  16'd18, 1'b0, 2, 0);
    run_job(16'd143, 16'd78, 1'b0, 0, 10);
    run_job(16'd35,  16'd0,  1'b0, 0, 2);
    run_job(16'd91,  16'd65, 1'b0, TMO, 0);

    // Reset pulsed while the core is busy on (1071, 462)
    core_hang = 1'b1;
    in_valid = 1'b1; in_a = 16'd1071; in_b = 16'd462;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
`ifdef GCD_STATS_EN
    exp_jobs = 16'd0;
    exp_max  = 0;
`endif
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check_eq("midrst_no_output", seen, 0);
    end
    run_job(16'd1071, 16'd462, 1'b0, 4, 1);

    for (int j = 0; j < 30; j++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(1, 4000));
      rb = W'($urandom_range(1, 4000));
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_job(ra, rb, ($urandom_range(0, 5) == 0), $urandom_range(0, TMO), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
